// File: rtl/simplerisc_pkg.sv
// SimpleRISC shared definitions: opcodes, ALU controls, branch codes,
// immediate modifiers and the decoded bundle.
package simplerisc_pkg;

  localparam int XLEN = 32;
  localparam int OPW  = 5;
  localparam int ALUW = 5;
  localparam int REGW = 4;
  localparam int BRW  = 3;

  localparam logic [OPW-1:0] OP_ADD  = 5'b00000;
  localparam logic [OPW-1:0] OP_SUB  = 5'b00001;
  localparam logic [OPW-1:0] OP_MUL  = 5'b00010;
  localparam logic [OPW-1:0] OP_DIV  = 5'b00011;
  localparam logic [OPW-1:0] OP_MOD  = 5'b00100;
  localparam logic [OPW-1:0] OP_CMP  = 5'b00101;
  localparam logic [OPW-1:0] OP_AND  = 5'b00110;
  localparam logic [OPW-1:0] OP_OR   = 5'b00111;
  localparam logic [OPW-1:0] OP_NOT  = 5'b01000;
  localparam logic [OPW-1:0] OP_MOV  = 5'b01001;
  localparam logic [OPW-1:0] OP_LSL  = 5'b01010;
  localparam logic [OPW-1:0] OP_LSR  = 5'b01011;
  localparam logic [OPW-1:0] OP_ASR  = 5'b01100;
  localparam logic [OPW-1:0] OP_NOP  = 5'b01101;
  localparam logic [OPW-1:0] OP_LD   = 5'b01110;
  localparam logic [OPW-1:0] OP_ST   = 5'b01111;
  localparam logic [OPW-1:0] OP_BEQ  = 5'b10000;
  localparam logic [OPW-1:0] OP_BGT  = 5'b10001;
  localparam logic [OPW-1:0] OP_B    = 5'b10010;
  localparam logic [OPW-1:0] OP_CALL = 5'b10011;
  localparam logic [OPW-1:0] OP_RET  = 5'b10100;

  localparam logic [ALUW-1:0] ALU_ADD = 5'b00000;
  localparam logic [ALUW-1:0] ALU_SUB = 5'b00001;
  localparam logic [ALUW-1:0] ALU_MUL = 5'b00010;
  localparam logic [ALUW-1:0] ALU_DIV = 5'b00011;
  localparam logic [ALUW-1:0] ALU_MOD = 5'b00100;
  localparam logic [ALUW-1:0] ALU_CMP = 5'b00101;
  localparam logic [ALUW-1:0] ALU_AND = 5'b00110;
  localparam logic [ALUW-1:0] ALU_OR  = 5'b00111;
  localparam logic [ALUW-1:0] ALU_NOT = 5'b01000;
  localparam logic [ALUW-1:0] ALU_LSL = 5'b01001;
  localparam logic [ALUW-1:0] ALU_LSR = 5'b01010;
  localparam logic [ALUW-1:0] ALU_ASR = 5'b01011;

  localparam logic [BRW-1:0] BR_NONE = 3'd0;
  localparam logic [BRW-1:0] BR_BEQ  = 3'd1;
  localparam logic [BRW-1:0] BR_BGT  = 3'd2;
  localparam logic [BRW-1:0] BR_B    = 3'd3;
  localparam logic [BRW-1:0] BR_CALL = 3'd4;
  localparam logic [BRW-1:0] BR_RET  = 3'd5;

  localparam logic [1:0] MOD_SEXT = 2'b00;
  localparam logic [1:0] MOD_ZEXT = 2'b01;
  localparam logic [1:0] MOD_HIGH = 2'b10;

  typedef struct packed {
    logic [ALUW-1:0] alu_control;
    logic [REGW-1:0] rd;
    logic [REGW-1:0] rs1;
    logic [REGW-1:0] rs2;
    logic            is_imm;
    logic [XLEN-1:0] imm_val;
    logic            a_zero;
    logic            wb_en;
    logic            mem_rd;
    logic            mem_wr;
    logic [BRW-1:0]  br_type;
    logic [XLEN-1:0] br_offset;
    logic            illegal;
  } dec_t;

  // Modifier 11 is unassigned and behaves like plain sign extension.
  function automatic logic [XLEN-1:0] ext_imm(
    input logic [1:0]  m,
    input logic [15:0] v
  );
    unique case (m)
      MOD_ZEXT: ext_imm = {16'h0, v};
      MOD_HIGH: ext_imm = {v, 16'h0};
      default:  ext_imm = {{16{v[15]}}, v};
    endcase
  endfunction

endpackage

// File: rtl/simplerisc_decode_comb.sv
// Combinational SimpleRISC decoder: one instruction word to one
// decoded bundle.
module simplerisc_decode_comb
  import simplerisc_pkg::*;
#(
  parameter logic [REGW-1:0] RA_REG   = 4'd15,
  parameter int              BR_SHIFT = 2
) (
  input  logic [XLEN-1:0] inst,
  output dec_t            dec
);

  logic [OPW-1:0]  op;
  logic [XLEN-1:0] off_sx;
  logic            use_imm;

  assign op     = inst[31:27];
  assign off_sx = {{(XLEN-27){inst[26]}}, inst[26:0]};

  always_comb begin
    dec           = '0;
    use_imm       = 1'b0;
    dec.rd        = inst[25:22];
    dec.rs1       = inst[21:18];
    dec.rs2       = inst[17:14];
    dec.br_offset = off_sx << BR_SHIFT;
    unique case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD,
      OP_AND, OP_OR, OP_NOT: begin
        dec.alu_control = op;
        dec.wb_en       = 1'b1;
        use_imm         = 1'b1;
      end
      OP_CMP: begin
        dec.alu_control = ALU_CMP;
        use_imm         = 1'b1;
      end
      OP_MOV: begin
        dec.alu_control = ALU_ADD;
        dec.a_zero      = 1'b1;
        dec.wb_en       = 1'b1;
        use_imm         = 1'b1;
      end
      OP_LSL, OP_LSR, OP_ASR: begin
        dec.alu_control = op - 5'd1;
        dec.wb_en       = 1'b1;
        use_imm         = 1'b1;
      end
      OP_NOP: ;
      OP_LD: begin
        dec.wb_en  = 1'b1;
        dec.mem_rd = 1'b1;
        use_imm    = 1'b1;
      end
      OP_ST: begin
        dec.rs2    = inst[25:22];
        dec.mem_wr = 1'b1;
        use_imm    = 1'b1;
      end
      OP_BEQ: dec.br_type = BR_BEQ;
      OP_BGT: dec.br_type = BR_BGT;
      OP_B:   dec.br_type = BR_B;
      OP_CALL: begin
        dec.br_type = BR_CALL;
        dec.rd      = RA_REG;
        dec.wb_en   = 1'b1;
      end
      OP_RET: begin
        dec.br_type = BR_RET;
        dec.rs1     = RA_REG;
      end
      default: dec.illegal = 1'b1;
    endcase
    if (use_imm && inst[26]) begin
      dec.is_imm  = 1'b1;
      dec.imm_val = ext_imm(inst[17:16], inst[15:0]);
    end
  end

endmodule

// File: rtl/simplerisc_decode_stage.sv
// Decode pipeline stage: registered output slot plus a one-entry skid
// so the upstream ready is a flop and throughput stays at one per cycle.
module simplerisc_decode_stage
  import simplerisc_pkg::*;
#(
  parameter logic [REGW-1:0] RA_REG   = 4'd15,
  parameter int              BR_SHIFT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inst_valid,
  input  logic [XLEN-1:0]  inst,
  output logic             inst_ready,
  output logic             dec_valid,
  input  logic             dec_ready,
  output logic [ALUW-1:0]  alu_control,
  output logic [REGW-1:0]  rd,
  output logic [REGW-1:0]  rs1,
  output logic [REGW-1:0]  rs2,
  output logic             is_imm,
  output logic [XLEN-1:0]  imm_val,
  output logic             a_zero,
  output logic             wb_en,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic [BRW-1:0]   br_type,
  output logic [XLEN-1:0]  br_offset,
  output logic             illegal
);

  dec_t dec_new;
  dec_t out_q, out_d;
  dec_t skid_q, skid_d;
  logic valid_q, valid_d;
  logic skid_full_q, skid_full_d;
  logic accept, slot_free;

  simplerisc_decode_comb #(
    .RA_REG   (RA_REG),
    .BR_SHIFT (BR_SHIFT)
  ) u_comb (
    .inst (inst),
    .dec  (dec_new)
  );

  assign inst_ready = ~skid_full_q;
  assign accept     = inst_valid & inst_ready;
  assign slot_free  = ~valid_q | dec_ready;

  // A full skid blocks accepts, so it never refills while it drains.
  always_comb begin
    out_d       = out_q;
    valid_d     = valid_q;
    skid_d      = skid_q;
    skid_full_d = skid_full_q;
    if (slot_free) begin
      if (skid_full_q) begin
        out_d       = skid_q;
        valid_d     = 1'b1;
        skid_full_d = 1'b0;
      end else if (accept) begin
        out_d   = dec_new;
        valid_d = 1'b1;
      end else begin
        valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d      = dec_new;
      skid_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q       <= '0;
      skid_q      <= '0;
      valid_q     <= 1'b0;
      skid_full_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      skid_q      <= skid_d;
      valid_q     <= valid_d;
      skid_full_q <= skid_full_d;
    end
  end

  assign dec_valid   = valid_q;
  assign alu_control = out_q.alu_control;
  assign rd          = out_q.rd;
  assign rs1         = out_q.rs1;
  assign rs2         = out_q.rs2;
  assign is_imm      = out_q.is_imm;
  assign imm_val     = out_q.imm_val;
  assign a_zero      = out_q.a_zero;
  assign wb_en       = out_q.wb_en;
  assign mem_rd      = out_q.mem_rd;
  assign mem_wr      = out_q.mem_wr;
  assign br_type     = out_q.br_type;
  assign br_offset   = out_q.br_offset;
  assign illegal     = out_q.illegal;

endmodule

// File: tb/tb_simplerisc_decode_stage.sv
// Directed bench for simplerisc_decode_stage: decode vector table plus
// skid/backpressure and mid-stream reset sequences.
module tb_simplerisc_decode_stage;
  import simplerisc_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_valid;
  logic [31:0] inst;
  logic        inst_ready;
  logic        dec_valid;
  logic        dec_ready;
  logic [4:0]  alu_control;
  logic [3:0]  rd, rs1, rs2;
  logic        is_imm, a_zero, wb_en, mem_rd, mem_wr, illegal;
  logic [31:0] imm_val, br_offset;
  logic [2:0]  br_type;
  dec_t        act;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  simplerisc_decode_stage dut (
    .clk         (clk),
    .rst         (rst),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_ready  (inst_ready),
    .dec_valid   (dec_valid),
    .dec_ready   (dec_ready),
    .alu_control (alu_control),
    .rd          (rd),
    .rs1         (rs1),
    .rs2         (rs2),
    .is_imm      (is_imm),
    .imm_val     (imm_val),
    .a_zero      (a_zero),
    .wb_en       (wb_en),
    .mem_rd      (mem_rd),
    .mem_wr      (mem_wr),
    .br_type     (br_type),
    .br_offset   (br_offset),
    .illegal     (illegal)
  );

  assign act = {alu_control, rd, rs1, rs2, is_imm, imm_val, a_zero,
                wb_en, mem_rd, mem_wr, br_type, br_offset, illegal};

  typedef struct {
    logic [31:0] inst;
    dec_t        exp;
    bit          chk_off;
  } vec_t;

  vec_t vecs[13];

  function automatic dec_t mk(
    input logic [4:0]  alu,
    input logic [3:0]  rd_, rs1_, rs2_,
    input logic        imm_,
    input logic [31:0] iv,
    input logic        az, wb, mr, mw,
    input logic [2:0]  br,
    input logic [31:0] off,
    input logic        ill
  );
    mk = {alu, rd_, rs1_, rs2_, imm_, iv, az, wb, mr, mw, br, off, ill};
  endfunction

  task automatic chk_b(input string nm, input dec_t a, input dec_t e,
                       input bit co);
    n_chk++;
    if (!co) a.br_offset = e.br_offset;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, a, e);
    end
  endtask

  task automatic chk_v(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, a, e);
    end
  endtask

  task automatic present(input logic [31:0] w, input logic v);
    inst       = w;
    inst_valid = v;
  endtask

  initial begin
    int wi, got, cyc;
    int sk[3];
    bit seen;

    vecs[0]  = '{32'h0448FFFB, mk(ALU_ADD, 1, 2, 3, 1, 32'hFFFFFFFB,
                 0, 1, 0, 0, BR_NONE, 32'hF123FFEC, 0), 1};
    vecs[1]  = '{32'h4CC21234, mk(ALU_ADD, 3, 0, 8, 1, 32'h12340000,
                 1, 1, 0, 0, BR_NONE, 0, 0), 0};
    vecs[2]  = '{32'h51158000, mk(ALU_LSL, 4, 5, 6, 0, 0,
                 0, 1, 0, 0, BR_NONE, 0, 0), 0};
    vecs[3]  = '{32'h87FFFFFE, mk(ALU_ADD, 15, 15, 15, 0, 0,
                 0, 0, 0, 0, BR_BEQ, 32'hFFFFFFF8, 0), 1};
    vecs[4]  = '{32'hA8000000, mk(ALU_ADD, 0, 0, 0, 0, 0,
                 0, 0, 0, 0, BR_NONE, 0, 1), 1};
    vecs[5]  = '{32'h7DC80008, mk(ALU_ADD, 7, 2, 7, 1, 32'h8,
                 0, 0, 0, 1, BR_NONE, 0, 0), 0};
    vecs[6]  = '{32'h74D1FFFF, mk(ALU_ADD, 3, 4, 7, 1, 32'h0000FFFF,
                 0, 1, 1, 0, BR_NONE, 0, 0), 0};
    vecs[7]  = '{32'h2C078000, mk(ALU_CMP, 0, 1, 14, 1, 32'hFFFF8000,
                 0, 0, 0, 0, BR_NONE, 0, 0), 0};
    vecs[8]  = '{32'h98000004, mk(ALU_ADD, 15, 0, 0, 0, 0,
                 0, 1, 0, 0, BR_CALL, 32'h10, 0), 1};
    vecs[9]  = '{32'hA0000000, mk(ALU_ADD, 0, 15, 0, 0, 0,
                 0, 0, 0, 0, BR_RET, 0, 0), 1};
    vecs[10] = '{32'h608D0000, mk(ALU_ASR, 2, 3, 4, 0, 0,
                 0, 1, 0, 0, BR_NONE, 0, 0), 0};
    vecs[11] = '{32'h68000000, mk(ALU_ADD, 0, 0, 0, 0, 0,
                 0, 0, 0, 0, BR_NONE, 0, 0), 1};
    vecs[12] = '{32'h0848CABC, mk(ALU_SUB, 1, 2, 3, 0, 0,
                 0, 1, 0, 0, BR_NONE, 0, 0), 0};

    rst = 1'b1;
    dec_ready = 1'b0;
    present(32'h0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_v("reset dec_valid", {31'h0, dec_valid}, 0);
    chk_v("reset inst_ready", {31'h0, inst_ready}, 1);
    chk_b("reset bundle", act, '0, 1);
    rst = 1'b0;

    // Table: one word at a time, drained immediately
    dec_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      present(vecs[i].inst, 1'b1);
      @(negedge clk);
      present(32'h0, 1'b0);
      chk_v($sformatf("vec%0d dec_valid", i), {31'h0, dec_valid}, 1);
      chk_b($sformatf("vec%0d bundle", i), act, vecs[i].exp,
            vecs[i].chk_off);
    end
    @(negedge clk);
    chk_v("idle dec_valid", {31'h0, dec_valid}, 0);

    // Backpressure: three words, sink stalled for four cycles
    sk = '{0, 2, 5};
    wi = 0;
    got = 0;
    cyc = 0;
    while (got < 3 && cyc < 40) begin
      @(negedge clk);
      dec_ready = (cyc >= 4);
      if (wi < 3) present(vecs[sk[wi]].inst, 1'b1);
      else present(32'h0, 1'b0);
      if (cyc == 3) begin
        chk_v("skid accepted", wi, 2);
        chk_v("skid inst_ready", {31'h0, inst_ready}, 0);
        chk_b("skid held stable", act, vecs[sk[0]].exp, 0);
      end
      seen = inst_valid && inst_ready;
      if (dec_valid && dec_ready) begin
        chk_b($sformatf("skid order %0d", got), act,
              vecs[sk[got]].exp, 0);
        got++;
      end
      @(posedge clk);
      if (seen) wi++;
      cyc++;
    end
    chk_v("skid drained count", got, 3);
    @(negedge clk);
    present(32'h0, 1'b0);
    chk_v("skid no duplicate", {31'h0, dec_valid}, 0);

    // Reset with both slot and skid occupied
    dec_ready = 1'b0;
    present(vecs[6].inst, 1'b1);
    @(negedge clk);
    present(vecs[10].inst, 1'b1);
    @(negedge clk);
    chk_v("pre-reset inst_ready", {31'h0, inst_ready}, 0);
    present(32'h0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_v("mid reset dec_valid", {31'h0, dec_valid}, 0);
    chk_v("mid reset inst_ready", {31'h0, inst_ready}, 1);
    chk_b("mid reset bundle", act, '0, 1);
    @(negedge clk);
    rst = 1'b0;
    dec_ready = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (dec_valid) seen = 1'b1;
    end
    chk_v("post reset no output", {31'h0, seen}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
